// File: rtl/full_tap_src_pkg.sv
// Shared types for the fully-connected stage tap path: the packed float word
// and the tap-source FSM state encoding.
package full_tap_src_pkg;

    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  expo;
    } float_24_8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_FIN
    } full_tap_src_state_t;

endpackage

// File: rtl/full_tap_src_mem.sv
// Tap staging register file: NUM_TAPS float words, synchronous write and
// combinational read. Out-of-range addresses write nothing and read zero.
module full_tap_src_mem
    import full_tap_src_pkg::*;
#(
    parameter int NUM_TAPS = 24,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  float_24_8         wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output float_24_8         rd_data
);

    float_24_8 [NUM_TAPS-1:0] mem_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i)))
                mem_q[i] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (rd_addr == ADDR_W'(i))
                rd_data = mem_q[i];
        end
    end

endmodule

// File: rtl/full_tap_src.sv
// Streams the staged taps into a fully-connected stage as a vld/rdy/fst burst,
// then waits for load_finish or times out.
module full_tap_src
    import full_tap_src_pkg::*;
#(
    parameter int NUM_TAPS    = 24,
    parameter int ADDR_W      = 5,
    parameter int FIN_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  float_24_8         cfg_data,
    input  logic              start,
    output float_24_8         tap_in,
    output logic              tap_in_fst,
    output logic              tap_in_vld,
    input  logic              tap_in_rdy,
    input  logic              load_finish,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = (FIN_TIMEOUT < 2) ? 1 : $clog2(FIN_TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FIN_TIMEOUT - 1);

    full_tap_src_state_t state;
    logic [ADDR_W-1:0]   idx;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   rd_addr;
    float_24_8           rd_data;
    logic                xfer;

    // Prefetch the word after the one on the bus so a transfer can reload the
    // output register without any path from tap_in_rdy to tap_in.
    assign rd_addr = (state == SEND) ? idx + ADDR_W'(1) : '0;
    assign xfer    = tap_in_vld & tap_in_rdy;

    full_tap_src_mem #(
        .NUM_TAPS (NUM_TAPS),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .wr_en    (cfg_wr),
        .wr_addr  (cfg_addr),
        .wr_data  (cfg_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            tap_in     <= '0;
            tap_in_fst <= 1'b0;
            tap_in_vld <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    idx        <= '0;
                    cnt        <= '0;
                    tap_in     <= rd_data;
                    tap_in_fst <= 1'b1;
                    if (start) begin
                        state      <= SEND;
                        tap_in_vld <= 1'b1;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        tap_in_fst <= 1'b0;
                        if (idx == LAST_IDX) begin
                            state      <= WAIT_FIN;
                            tap_in_vld <= 1'b0;
                            idx        <= '0;
                            cnt        <= '0;
                        end else begin
                            idx    <= idx + ADDR_W'(1);
                            tap_in <= rd_data;
                        end
                    end
                end
                WAIT_FIN: begin
                    // An acknowledge in the last allowed cycle still wins over the timeout.
                    if (load_finish) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_full_tap_src.sv
// Scoreboard bench for full_tap_src: stimulus pushes the expected burst from a
// memory model, an independent monitor pops and checks every transfer.
module tb_full_tap_src;
    import full_tap_src_pkg::*;

    localparam int NT = 24;
    localparam int AW = 5;
    localparam int FT = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_wr;
    logic [AW-1:0] cfg_addr;
    logic [31:0]   cfg_data;
    logic          start;
    float_24_8     tap_in;
    logic          tap_in_fst, tap_in_vld, tap_in_rdy;
    logic          load_finish, busy, done, err;

    full_tap_src #(.NUM_TAPS(NT), .ADDR_W(AW), .FIN_TIMEOUT(FT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .start       (start),
        .tap_in      (tap_in),
        .tap_in_fst  (tap_in_fst),
        .tap_in_vld  (tap_in_vld),
        .tap_in_rdy  (tap_in_rdy),
        .load_finish (load_finish),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        f;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_m[NT];
    int cmp_cnt = 0, err_cnt = 0, xfers = 0;
    int rdy_mode = 0, stall_at = 0, stall_left = 0, base = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        cmp_cnt++;
        if (act !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic fail(string nm);
        cmp_cnt++;
        err_cnt++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Monitor: samples just after the falling edge, i.e. the values the next
    // rising edge will see.
    initial begin
        logic        ps;
        logic [31:0] pd;
        logic        pf;
        exp_t        e;
        ps = 1'b0; pd = '0; pf = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (reset) begin
                ps = 1'b0;
            end else begin
                if (ps) begin
                    chk("stall_vld", 32'(tap_in_vld), 1);
                    chk("stall_data", tap_in, pd);
                    chk("stall_fst", 32'(tap_in_fst), 32'(pf));
                end
                if (tap_in_vld && tap_in_rdy) begin
                    xfers++;
                    if (exp_q.size() == 0) fail("extra_word");
                    else begin
                        e = exp_q.pop_front();
                        chk("word", tap_in, e.d);
                        chk("word_fst", 32'(tap_in_fst), 32'(e.f));
                    end
                end
                ps = tap_in_vld && !tap_in_rdy;
                pd = tap_in;
                pf = tap_in_fst;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        case (rdy_mode)
            0: tap_in_rdy = 1'b1;
            1: tap_in_rdy = 1'($urandom_range(0, 1));
            default: begin
                if (xfers - base == stall_at && stall_left > 0) begin
                    tap_in_rdy = 1'b0;
                    stall_left--;
                end else tap_in_rdy = 1'b1;
            end
        endcase
    endtask

    task automatic host_wr(int a, logic [31:0] d);
        tick();
        cfg_wr = 1'b1; cfg_addr = a[AW-1:0]; cfg_data = d;
        if (a < NT) mem_m[a] = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic do_start();
        tick();
        for (int k = 0; k < NT; k++) begin
            exp_t e;
            e.d = mem_m[k];
            e.f = (k == 0);
            exp_q.push_back(e);
        end
        base  = xfers;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("start_vld", 32'(tap_in_vld), 1);
        chk("start_fst", 32'(tap_in_fst), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_err_clr", 32'(err), 0);
    endtask

    // Returns in the first cycle after the target transfer; want_cyc < 0 skips the cycle check.
    task automatic wait_xfers(int target, int want_cyc, string nm);
        int n = 0;
        while (xfers < target && n < 1000) begin
            tick();
            n++;
        end
        if (xfers < target) fail({nm, "_timeout"});
        else if (want_cyc >= 0) chk({nm, "_cycles"}, n, want_cyc);
    endtask

    task automatic finish_ack();
        tick(); tick();
        load_finish = 1'b1;
        tick();
        load_finish = 1'b0;
        #1;
        chk("ack_done", 32'(done), 1);
        chk("ack_busy", 32'(busy), 0);
        chk("ack_err", 32'(err), 0);
        chk("ack_q_empty", exp_q.size(), 0);
        tick(); #1;
        chk("done_pulse", 32'(done), 0);
    endtask

    initial begin
        bit wrote;
        int n;
        reset = 1'b1; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; tap_in_rdy = 1'b1; load_finish = 1'b0;
        #12;
        chk("rst_vld", 32'(tap_in_vld), 0);
        chk("rst_fst", 32'(tap_in_fst), 0);
        chk("rst_data", tap_in, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        tick();
        reset = 1'b0;

        // Write and single burst at full rate
        for (int k = 0; k < NT; k++) host_wr(k, 32'h3F80_0000 + 32'(k));
        rdy_mode = 0;
        do_start();
        wait_xfers(base + NT, NT, "burst1");
        finish_ack();

        // Random back-pressure with ignored start and load_finish mid-burst
        rdy_mode = 1;
        do_start();
        wait_xfers(base + 8, -1, "bp_mid");
        tick();
        start = 1'b1; load_finish = 1'b1;
        tick();
        start = 1'b0; load_finish = 1'b0;
        wait_xfers(base + NT, -1, "bp_end");
        tick(); tick(); #1;
        chk("bp_vld_low", 32'(tap_in_vld), 0);
        chk("bp_still_busy", 32'(busy), 1);
        chk("bp_no_done", 32'(done), 0);
        finish_ack();

        // Out-of-range write plus some random contents
        host_wr(30, $urandom);
        for (int k = 0; k < 6; k++) host_wr($urandom_range(0, NT - 1), $urandom);
        do_start();
        wait_xfers(base + NT, -1, "oor");
        finish_ack();

        // Timeout: err exactly FT+1 cycles after the last transfer
        rdy_mode = 0;
        do_start();
        wait_xfers(base + NT, NT, "to");
        for (int c = 1; c <= FT + 1; c++) begin
            if (c > 1) tick();
            #1;
            chk("to_done", 32'(done), 0);
            chk("to_err", 32'(err), (c == FT + 1) ? 1 : 0);
            chk("to_busy", 32'(busy), (c == FT + 1) ? 0 : 1);
        end
        do_start();
        wait_xfers(base + NT, NT, "to_resend");
        finish_ack();

        // Reset after word 10
        do_start();
        wait_xfers(base + 11, -1, "rst_mid");
        tap_in_rdy = 1'b0;
        reset = 1'b1;
        #2;
        chk("rmid_vld", 32'(tap_in_vld), 0);
        chk("rmid_fst", 32'(tap_in_fst), 0);
        chk("rmid_data", tap_in, 0);
        chk("rmid_busy", 32'(busy), 0);
        chk("rmid_err", 32'(err), 0);
        exp_q.delete();
        tick(); tick();
        reset = 1'b0;
        do_start();
        wait_xfers(base + NT, NT, "rst_rerun");
        finish_ack();

        // Write mem[5] while word 5 is stalled
        rdy_mode = 2; stall_at = 5; stall_left = 3; wrote = 1'b0;
        do_start();
        n = 0;
        while (xfers < base + NT && n < 1000) begin
            tick();
            n++;
            if (!wrote && xfers - base == 5 && stall_left == 1) begin
                cfg_wr = 1'b1; cfg_addr = 5'd5; cfg_data = 32'hCAFE_0005;
                mem_m[5] = 32'hCAFE_0005;
                wrote = 1'b1;
            end else cfg_wr = 1'b0;
        end
        cfg_wr = 1'b0;
        if (xfers < base + NT) fail("stall_timeout");
        chk("stall_wrote", 32'(wrote), 1);
        finish_ack();
        rdy_mode = 0;
        do_start();
        wait_xfers(base + NT, NT, "stall_next");
        finish_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
